// File: rtl/e_mdu_if.sv
// E-stage MDU interface: issue bus from E-stage control, HI/LO state and hazard flags back.
interface e_mdu_if;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic [3:0]  mdu_op;
  logic        start;
  logic        busy;
  logic        busy_or_start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_HL_data;

  modport master (
    output E_A, E_B, mdu_op, start,
    input  busy, busy_or_start, HI, LO, E_HL_data
  );

  modport slave (
    input  E_A, E_B, mdu_op, start,
    output busy, busy_or_start, HI, LO, E_HL_data
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO, with a busy counter modelling latency.
// Define MDU_MADD_EN to enable MADD/MADDU (ops 9/10); otherwise they decode as NONE.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave mdu
);

  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMflo  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd9;
  localparam logic [3:0] OpMaddu = 4'd10;
`endif

  function automatic logic is_md_op(input logic [3:0] op);
    case (op)
      OpMult, OpMultu, OpDiv, OpDivu: return 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu:                return 1'b1;
`endif
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_mult_op(input logic [3:0] op);
    case (op)
      OpMult, OpMultu: return 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu: return 1'b1;
`endif
      default:         return 1'b0;
    endcase
  endfunction

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;

  logic busy, issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OpNone;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy  = (cnt_q != 4'd0);
  assign issue = mdu.start & ~busy;

  // Result datapath, always from the latched operands.
  logic signed [63:0] a_sx, b_sx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;

  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
    abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    abs_b  = b_q[31] ? (32'd0 - b_q) : b_q;
    q_mag  = abs_a / abs_b;
    r_mag  = abs_a % abs_b;
    q_s    = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    r_s    = a_q[31] ? (32'd0 - r_mag) : r_mag;
    q_u    = a_q / b_q;
    r_u    = a_q % b_q;
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    cnt_d = cnt_q;
    if (issue) begin
      if (mdu.mdu_op == OpMthi) begin
        hi_d = mdu.E_A;
      end else if (mdu.mdu_op == OpMtlo) begin
        lo_d = mdu.E_A;
      end else if (is_md_op(mdu.mdu_op)) begin
        a_d   = mdu.E_A;
        b_d   = mdu.E_B;
        op_d  = mdu.mdu_op;
        cnt_d = is_mult_op(mdu.mdu_op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end
    end else if (busy) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        case (op_q)
          OpMult:  {hi_d, lo_d} = prod_s;
          OpMultu: {hi_d, lo_d} = prod_u;
          OpDiv:   if (b_q != 32'd0) {hi_d, lo_d} = {r_s, q_s};
          OpDivu:  if (b_q != 32'd0) {hi_d, lo_d} = {r_u, q_u};
`ifdef MDU_MADD_EN
          OpMadd:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
          OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
          default: ;
        endcase
      end
    end
  end

  assign mdu.busy          = busy;
  assign mdu.busy_or_start = busy | (mdu.start & is_md_op(mdu.mdu_op));
  assign mdu.HI            = hi_q;
  assign mdu.LO            = lo_q;
  assign mdu.E_HL_data     = (mdu.mdu_op == OpMflo) ? lo_q : hi_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios then random ops against a 64-bit model.
module tb_e_mdu;
  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  e_mdu_if u_if ();

  e_mdu #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .mdu  (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_is_md(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd3, 4'd4: return 1'b1;
`ifdef MDU_MADD_EN
      4'd9, 4'd10:            return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

  // Architectural result of a completed mult/div, using whole-number arithmetic.
  task automatic model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_in, input logic [31:0] lo_in,
                          output logic [31:0] hi_out, output logic [31:0] lo_out);
    longint sa, sb, q, r;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    acc = {hi_in, lo_in};
    hi_out = hi_in;
    lo_out = lo_in;
    case (op)
      4'd1: begin p = 64'(sa * sb); {hi_out, lo_out} = p; end
      4'd2: begin p = 64'(a) * 64'(b); {hi_out, lo_out} = p; end
      4'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        lo_out = q[31:0];
        hi_out = r[31:0];
      end
      4'd4: if (b != 0) begin
        lo_out = a / b;
        hi_out = a % b;
      end
      4'd9: begin p = 64'(sa * sb); {hi_out, lo_out} = acc + p; end
      4'd10: begin p = 64'(a) * 64'(b); {hi_out, lo_out} = acc + p; end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hammer);
    logic [31:0] e_hi, e_lo;
    bit md;
    int n;
    md = model_is_md(op);
    u_if.E_A = a;
    u_if.E_B = b;
    u_if.mdu_op = op;
    u_if.start = 1'b1;
    #1;
    chk("busy_or_start_issue", 32'(u_if.busy_or_start), 32'(md));
    if (op == 4'd7) chk("mfhi_data", u_if.E_HL_data, m_hi);
    if (op == 4'd8) chk("mflo_data", u_if.E_HL_data, m_lo);
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    u_if.mdu_op = 4'd0;
    u_if.E_A = $urandom;
    u_if.E_B = $urandom;
    if (!md) begin
      if (op == 4'd5) m_hi = a;
      if (op == 4'd6) m_lo = a;
      chk("busy_nonmd", 32'(u_if.busy), 32'd0);
      chk("hi_nonmd", u_if.HI, m_hi);
      chk("lo_nonmd", u_if.LO, m_lo);
      return;
    end
    model_md(op, a, b, m_hi, m_lo, e_hi, e_lo);
    n = (op == 4'd3 || op == 4'd4) ? int'(DivCycles) : int'(MultCycles);
    for (int i = 0; i < n; i++) begin
      chk("busy_during", 32'(u_if.busy), 32'd1);
      chk("hi_during", u_if.HI, m_hi);
      chk("lo_during", u_if.LO, m_lo);
      if (hammer) begin
        u_if.start = 1'b1;
        u_if.mdu_op = 4'd6;
        u_if.E_A = $urandom;
        #1;
        chk("busy_or_start_busy", 32'(u_if.busy_or_start), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    u_if.start = 1'b0;
    u_if.mdu_op = 4'd0;
    m_hi = e_hi;
    m_lo = e_lo;
    chk("busy_done", 32'(u_if.busy), 32'd0);
    chk("hi_done", u_if.HI, m_hi);
    chk("lo_done", u_if.LO, m_lo);
    u_if.mdu_op = 4'd8;
    #1;
    chk("e_hl_lo", u_if.E_HL_data, m_lo);
    u_if.mdu_op = 4'd7;
    #1;
    chk("e_hl_hi", u_if.E_HL_data, m_hi);
    u_if.mdu_op = 4'd0;
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    u_if.E_A = '0;
    u_if.E_B = '0;
    u_if.mdu_op = 4'd0;
    u_if.start = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("reset_busy", 32'(u_if.busy), 32'd0);
    chk("reset_hi", u_if.HI, 32'd0);
    chk("reset_lo", u_if.LO, 32'd0);
    chk("reset_bos", 32'(u_if.busy_or_start), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("t1_hi", u_if.HI, 32'hFFFF_FFFF);
    chk("t1_lo", u_if.LO, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("t2_hi", u_if.HI, 32'h0000_0001);
    chk("t2_lo", u_if.LO, 32'hFFFF_FFFE);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("t3_lo", u_if.LO, 32'hFFFF_FFFD);
    chk("t3_hi", u_if.HI, 32'hFFFF_FFFF);
    run_op(4'd4, 32'h1234_5678, 32'd0, 1'b0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf_lo", u_if.LO, 32'h8000_0000);
    chk("ovf_hi", u_if.HI, 32'd0);
    run_op(4'd5, 32'h0000_1234, 32'd0, 1'b0);
    run_op(4'd7, 32'h0, 32'h0, 1'b0);
    run_op(4'd1, 32'h0001_0003, 32'hFFF0_0007, 1'b1);

    // Abort a DIV in its fourth busy cycle.
    u_if.E_A = 32'd100;
    u_if.E_B = 32'd7;
    u_if.mdu_op = 4'd3;
    u_if.start = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    u_if.mdu_op = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(u_if.busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(u_if.busy), 32'd0);
    chk("abort_hi", u_if.HI, 32'd0);
    chk("abort_lo", u_if.LO, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (DivCycles + 2) @(posedge clk);
    #1;
    chk("abort_late_busy", 32'(u_if.busy), 32'd0);
    chk("abort_late_hi", u_if.HI, 32'd0);
    chk("abort_late_lo", u_if.LO, 32'd0);

    run_op(4'd5, 32'd0, 32'd0, 1'b0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(4'd10, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    chk("maddu_hi", u_if.HI, 32'd1);
    chk("maddu_lo", u_if.LO, 32'd0);
`else
    chk("maddu_off_hi", u_if.HI, 32'd0);
    chk("maddu_off_lo", u_if.LO, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
